// File: rtl/text_pkg.sv
// Shared geometry, cell layout and address helpers for the text console buffer.
package text_pkg;

  localparam int COLS   = 240;
  localparam int ROWS   = 135;
  localparam int ADDR_W = 15;
  localparam int CELLS  = COLS * ROWS;

  typedef struct packed {
    logic [7:0] ascii;
    logic [3:0] fg;
    logic [3:0] bg;
  } cell_t;

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} sweep_state_e;

  // Both operands are below ROWS when in range, so one conditional subtract wraps the sum.
  function automatic logic [8:0] wrap_row(input logic [9:0] sum);
    if (sum >= 10'(ROWS)) return 9'(sum - 10'(ROWS));
    return sum[8:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [8:0] row, input logic [8:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell RAM: one write port, one registered read port, no reset.
module text_ram
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  cell_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output cell_t             rdata
);

  cell_t mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell store: 3-cycle read pipeline, handshaked writes, and clear/scroll sweeps
// over a row-offset ring so that a scroll only has to blank one row.
module text_buffer
  import text_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_bx,
  input  logic [8:0]  i_by,
  output logic [15:0] o_char,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [7:0]  i_wr_col,
  input  logic [7:0]  i_wr_row,
  input  logic [15:0] i_wr_data,
  input  logic        i_clr_req,
  input  logic        i_scroll_req,
  input  logic [7:0]  i_fill_attr,
  output logic        o_busy
);

  sweep_state_e      state, next_state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        offset;
  logic              clr_pend, scr_pend;
  logic [7:0]        clr_attr, scr_attr, sweep_attr;
  logic              alive;

  logic [ADDR_W-1:0] rd_addr_a;
  logic              in_range_a, in_range_b;
  cell_t             rd_word;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  cell_t             ram_wdata;
  logic              wr_in_range, sweep_last;
  logic [ADDR_W-1:0] wr_addr, scroll_base;
  cell_t             blank_cell;

  assign wr_in_range = (i_wr_col < 8'(COLS)) && (i_wr_row < 8'(ROWS));
  assign wr_addr     = cell_addr(wrap_row({2'b00, i_wr_row} + {2'b00, offset}), {1'b0, i_wr_col});
  assign scroll_base = cell_addr({1'b0, offset}, 9'd0);
  assign blank_cell  = {BLANK_CHAR, sweep_attr};
  assign o_busy      = (state != IDLE) || clr_pend || scr_pend;

  // Read pipeline: address/in_range, RAM read, then output select; never stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_addr_a  <= '0;
      in_range_a <= 1'b0;
      in_range_b <= 1'b0;
      o_char     <= '0;
    end else begin
      rd_addr_a  <= cell_addr(wrap_row({1'b0, i_by} + {2'b00, offset}), i_bx);
      in_range_a <= (i_bx < 9'(COLS)) && (i_by < 9'(ROWS));
      in_range_b <= in_range_a;
      o_char     <= in_range_b ? rd_word : '0;
    end
  end

  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = i_wr_data;
    o_wr_ready = 1'b0;
    sweep_last = 1'b0;
    case (state)
      IDLE: begin
        o_wr_ready = alive && !clr_pend && !scr_pend;
        if (clr_pend)      next_state = CLEAR;
        else if (scr_pend) next_state = SCROLL;
        else if (i_wr_valid && o_wr_ready && wr_in_range) ram_we = 1'b1;
      end
      CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = idx;
        ram_wdata  = blank_cell;
        sweep_last = (idx == ADDR_W'(CELLS - 1));
        if (sweep_last) next_state = IDLE;
      end
      SCROLL: begin
        ram_we     = 1'b1;
        ram_waddr  = scroll_base + idx;
        ram_wdata  = blank_cell;
        sweep_last = (idx == ADDR_W'(COLS - 1));
        if (sweep_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The sweep gets its own attr copy so a request merged mid-sweep cannot change it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      idx        <= '0;
      offset     <= '0;
      clr_pend   <= 1'b0;
      scr_pend   <= 1'b0;
      clr_attr   <= '0;
      scr_attr   <= '0;
      sweep_attr <= '0;
      alive      <= 1'b0;
    end else begin
      alive <= 1'b1;
      state <= next_state;
      idx   <= (state == IDLE) ? '0 : idx + ADDR_W'(1);
      if (state == IDLE && clr_pend) begin
        clr_pend   <= 1'b0;
        sweep_attr <= clr_attr;
      end else if (state == IDLE && scr_pend) begin
        scr_pend   <= 1'b0;
        sweep_attr <= scr_attr;
      end
      if (sweep_last) begin
        if (state == CLEAR)              offset <= 8'd0;
        else if (offset == 8'(ROWS - 1)) offset <= 8'd0;
        else                             offset <= offset + 8'd1;
      end
      if (i_clr_req) begin
        clr_pend <= 1'b1;
        clr_attr <= i_fill_attr;
      end
      if (i_scroll_req) begin
        scr_pend <= 1'b1;
        scr_attr <= i_fill_attr;
      end
    end
  end

  text_ram u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr_a),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: vector table plus hand-written sweep, scroll and reset sequences.
module tb_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  bx, by;
  logic [15:0] o_char;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_col, wr_row;
  logic [15:0] wr_data;
  logic        clr_req, scroll_req;
  logic [7:0]  fill_attr;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        do_wr;
    logic [7:0]  col;
    logic [7:0]  row;
    logic [15:0] data;
    logic [8:0]  rbx;
    logic [8:0]  rby;
    logic [15:0] expd;
  } vec_t;

  vec_t vecs [8];

  text_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bx         (bx),
    .i_by         (by),
    .o_char       (o_char),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_col     (wr_col),
    .i_wr_row     (wr_row),
    .i_wr_data    (wr_data),
    .i_clr_req    (clr_req),
    .i_scroll_req (scroll_req),
    .i_fill_attr  (fill_attr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic writeCell(input logic [7:0] col, input logic [7:0] row, input logic [15:0] data);
    int n = 0;
    wr_col = col; wr_row = row; wr_data = data; wr_valid = 1'b1;
    while (!wr_ready && n < 40000) begin
      tick();
      n++;
    end
    if (!wr_ready) timeoutFail("write_ready");
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic readCell(input logic [8:0] x, input logic [8:0] y, output logic [15:0] data);
    bx = x; by = y;
    tick(); tick(); tick();
    data = o_char;
    bx = 9'd300; by = 9'd0;
  endtask

  task automatic expectCell(input string name, input logic [8:0] x, input logic [8:0] y, input logic [15:0] expd);
    logic [15:0] got;
    readCell(x, y, got);
    checkOutput(name, got, expd);
  endtask

  task automatic pulseClear(input logic [7:0] attr);
    clr_req = 1'b1; fill_attr = attr;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic pulseScroll(input logic [7:0] attr);
    scroll_req = 1'b1; fill_attr = attr;
    tick();
    scroll_req = 1'b0;
  endtask

  // Counts cycles until o_busy falls and flags any write-ready seen while busy.
  task automatic waitIdle(output int n, output int ready_while_busy);
    n = 0;
    ready_while_busy = 0;
    while (busy && n < 40000) begin
      if (wr_ready) ready_while_busy++;
      tick();
      n++;
    end
    if (busy) timeoutFail("wait_idle");
  endtask

  task automatic applyStimulus(input int i, input vec_t v);
    if (v.do_wr) writeCell(v.col, v.row, v.data);
    expectCell($sformatf("table_%0d", i), v.rbx, v.rby, v.expd);
  endtask

  initial begin
    int n, rb;
    logic [15:0] got;

    rst = 1'b1; bx = 9'd300; by = 9'd0;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
    clr_req = 1'b0; scroll_req = 1'b0; fill_attr = '0;
    repeat (3) tick();
    checkOutput("reset_char", o_char, 16'h0000);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", wr_ready, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_reset", wr_ready, 1'b1);

    // Clear and two merged scrolls queued together, with a write held across them.
    clr_req = 1'b1; scroll_req = 1'b1; fill_attr = 8'h07;
    tick();
    clr_req = 1'b0; scroll_req = 1'b1; fill_attr = 8'h3C;
    checkOutput("ready_drop", wr_ready, 1'b0);
    tick();
    scroll_req = 1'b0;
    wr_col = 8'd10; wr_row = 8'd20; wr_data = 16'h5A3C; wr_valid = 1'b1;
    checkOutput("busy_after_pulse", busy, 1'b1);
    waitIdle(n, rb);
    checkOutput("clear_scroll_cycles", n, 32641);
    checkOutput("ready_while_busy", rb, 0);
    checkOutput("ready_after_sweeps", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    expectCell("held_write", 9'd10, 9'd20, 16'h5A3C);
    expectCell("clear_0_0", 9'd0, 9'd0, 16'h2007);
    expectCell("clear_11_20", 9'd11, 9'd20, 16'h2007);
    expectCell("clear_row133", 9'd0, 9'd133, 16'h2007);
    expectCell("merged_scroll_row134", 9'd0, 9'd134, 16'h203C);

    vecs[0] = '{1'b1, 8'd0,   8'd1,   16'h1111, 9'd0,   9'd1,   16'h1111};
    vecs[1] = '{1'b1, 8'd240, 8'd0,   16'hBEEF, 9'd0,   9'd1,   16'h1111};
    vecs[2] = '{1'b1, 8'd239, 8'd134, 16'h7F3A, 9'd239, 9'd134, 16'h7F3A};
    vecs[3] = '{1'b1, 8'd0,   8'd135, 16'hDEAD, 9'd0,   9'd0,   16'h2007};
    vecs[4] = '{1'b1, 8'd100, 8'd50,  16'hC0DE, 9'd240, 9'd50,  16'h0000};
    vecs[5] = '{1'b1, 8'd100, 8'd60,  16'h1234, 9'd100, 9'd135, 16'h0000};
    vecs[6] = '{1'b0, 8'd0,   8'd0,   16'h0000, 9'd100, 9'd50,  16'hC0DE};
    vecs[7] = '{1'b0, 8'd0,   8'd0,   16'h0000, 9'd100, 9'd60,  16'h1234};
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Latency: one-cycle in-range address between out-of-range ones.
    writeCell(8'd5, 8'd7, 16'h41F0);
    bx = 9'd240; by = 9'd7;
    repeat (4) tick();
    bx = 9'd5;
    tick();
    bx = 9'd240;
    checkOutput("latency_c1", o_char, 16'h0000);
    tick();
    checkOutput("latency_c2", o_char, 16'h0000);
    tick();
    checkOutput("latency_c3", o_char, 16'h41F0);
    tick();
    checkOutput("latency_c4", o_char, 16'h0000);
    bx = 9'd300; by = 9'd0;

    // Scroll one row with logical rows 0 and 1 filled.
    for (int c = 0; c < 240; c++) writeCell(8'(c), 8'd0, 16'h4112);
    for (int c = 0; c < 240; c++) writeCell(8'(c), 8'd1, 16'h4234);
    pulseScroll(8'h1E);
    waitIdle(n, rb);
    checkOutput("scroll_cycles", n, 241);
    expectCell("scroll_row0_c0", 9'd0, 9'd0, 16'h4234);
    expectCell("scroll_row0_c239", 9'd239, 9'd0, 16'h4234);
    expectCell("scroll_row134_c0", 9'd0, 9'd134, 16'h201E);
    expectCell("scroll_row134_c239", 9'd239, 9'd134, 16'h201E);
    expectCell("scroll_row133", 9'd0, 9'd133, 16'h203C);

    // 133 more scrolls bring the offset round to zero.
    for (int k = 0; k < 133; k++) begin
      pulseScroll(8'h00);
      waitIdle(n, rb);
      if (k == 0 || k == 132) checkOutput($sformatf("wrap_scroll_cycles_%0d", k), n, 241);
    end
    expectCell("wrap_0_0", 9'd0, 9'd0, 16'h203C);
    expectCell("wrap_239_0", 9'd239, 9'd0, 16'h7F3A);
    expectCell("wrap_0_1", 9'd0, 9'd1, 16'h201E);
    expectCell("wrap_5_134", 9'd5, 9'd134, 16'h2000);

    // Reset during a clear, right after address 999 has been written.
    writeCell(8'd39, 8'd4, 16'hA001);
    writeCell(8'd40, 8'd4, 16'hA002);
    writeCell(8'd41, 8'd4, 16'hA003);
    writeCell(8'd0, 8'd100, 16'hA004);
    pulseClear(8'h61);
    repeat (1001) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midclr_char", o_char, 16'h0000);
    checkOutput("midclr_busy", busy, 1'b0);
    tick();
    checkOutput("midclr_ready", wr_ready, 1'b1);
    expectCell("midclr_addr0", 9'd0, 9'd0, 16'h2061);
    expectCell("midclr_addr999", 9'd39, 9'd4, 16'h2061);
    expectCell("midclr_addr1000", 9'd40, 9'd4, 16'hA002);
    expectCell("midclr_addr1001", 9'd41, 9'd4, 16'hA003);
    expectCell("midclr_row100", 9'd0, 9'd100, 16'hA004);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell store for the 1920x1080 text console. It sits between timing_source and renderer.
- Read side: takes cell coordinates (bx, by) every pixel clock and returns the 16-bit cell word {ascii, fg, bg} that renderer consumes as i_char.
- Write side: accepts cell writes from the console controller through a valid/ready handshake.
- Also executes full-screen clear and one-row hardware scroll (row-offset ring) as internal sweeps.

Parameters:
- COLS, 240: cells per row (1920/8).
- ROWS, 135: cell rows (1080/8).
- BLANK_CHAR, 8'h20: ascii code written by clear and scroll sweeps.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_bx  in  9  read cell column from timing_source.
- i_by  in  9  read cell row from timing_source.
- o_char  out  16  cell word {ascii[15:8], fg[7:4], bg[3:0]}, to renderer i_char.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  write accepted this cycle when high together with i_wr_valid.
- i_wr_col  in  8  logical column of write.
- i_wr_row  in  8  logical row of write.
- i_wr_data  in  16  cell word to write.
- i_clr_req  in  1  single-cycle pulse: clear whole screen.
- i_scroll_req  in  1  single-cycle pulse: scroll up one row.
- i_fill_attr  in  8  {fg, bg} for blank cells; sampled with the corresponding request pulse.
- o_busy  out  1  high while a sweep is running or a request is pending.

Behaviour:
- Reset values: o_char = 0, o_wr_ready = 0, o_busy = 0, offset = 0, FSM = IDLE, pending flags cleared. RAM contents are not reset.
- Address map: phys_row = (logical_row + offset) wrapped into 0..ROWS-1, computed by compare-and-subtract with no modulo divider. Address = phys_row*COLS + col, 15 bits.
- Read pipeline, fixed latency 3 cycles from i_bx/i_by to o_char:
  - Stage A registers the address and in_range = (bx < COLS) && (by < ROWS).
  - Stage B is the registered RAM read.
  - Stage C sets o_char to the RAM word if in_range, else 16'h0000.
  - The read port never stalls.
- Write port is single-ported against sweeps; writes and sweeps never collide.
- Pending flags:
  - i_clr_req sets clr_pend and latches clr_attr.
  - i_scroll_req sets scr_pend and latches scr_attr.
  - A pulse arriving while the same flag is already set is merged: one action, latest attr.
- FSM states:
  - IDLE: o_wr_ready = !clr_pend && !scr_pend. Priority is clr_pend, then scr_pend, then write.
    - clr_pend: go to CLEAR with idx = 0 and clear clr_pend.
    - scr_pend: go to SCROLL with idx = 0 and clear scr_pend.
    - Write handshake: one RAM write per accepted beat. Out-of-range col/row completes the handshake but is discarded.
  - CLEAR: writes {BLANK_CHAR, clr_attr} to address idx, one per cycle, for idx 0..COLS*ROWS-1 (32400 cycles). On the last write it sets offset = 0 and returns to IDLE. A scroll pending during CLEAR is serviced afterwards.
  - SCROLL: writes {BLANK_CHAR, scr_attr} to row phys = offset, idx 0..COLS-1 (240 cycles). On the last write it sets offset = (offset == ROWS-1) ? 0 : offset+1 and returns to IDLE. The old top row thus becomes the blank bottom row.
- o_busy = (state != IDLE) || clr_pend || scr_pend.
- Reset mid-sweep: FSM aborts to IDLE, offset = 0, pending flags cleared, partially swept RAM left as-is.
- A request pulse on the same cycle as reset is lost.

Decomposition:
- Package text_pkg holds:
  - COLS, ROWS, ADDR_W = 15.
  - typedef cell_t packed struct {ascii[7:0], fg[3:0], bg[3:0]}.
  - typedef sweep_state_e {IDLE, CLEAR, SCROLL}.
- Sub-module text_ram: simple dual-port, one write port and one registered read port, 2^ADDR_W x 16, no reset, infers block RAM.
- Address wrap and multiply stay in text_buffer.

Test Plan:
- Read latency: write cell (col 5, row 7) = 16'h41F0, then drive bx = 5, by = 7 for one cycle -> o_char = 16'h41F0 exactly 3 cycles later; bx = 240 -> o_char = 16'h0000 3 cycles later.
- Handshake: hold i_wr_valid across an i_clr_req pulse -> o_wr_ready drops the next cycle, o_busy stays high 32400 cycles, and the write lands after the clear (cell reads written value; all others read 16'h2007 with attr 8'h07).
- Scroll: fill row 0 with 16'h4112 and row 1 with 16'h4234, scroll -> logical row 0 reads 16'h4234, row 134 reads {8'h20, attr}, offset = 1 after 240 sweep cycles.
- Wrap: issue 135 scrolls -> offset returns to 0; logical (0,0) maps to physical address 0 again.
- Priority/merge: pulse i_scroll_req twice and i_clr_req once in IDLE within 3 cycles -> exactly one CLEAR then one SCROLL; no write accepted until o_busy falls.
- Reset mid-clear: assert i_rst at sweep idx 1000 -> o_char = 0, o_busy = 0, o_wr_ready = 1 the first cycle after release; cells below address 1000 are blank and the rest are unchanged.
